// File: rtl/pc_fetch_unit.sv
// Program counter plus req/ack instruction fetch into IR; feeds PC+2 and branch target back to the next-PC mux.
// Latency: fetch_start to ir_valid is 2 cycles minimum (1 REQ cycle + DONE); memory wait states add 1 cycle each.
// Backpressure: REQ holds imem_req/imem_addr until imem_ack; pc_load/fetch_start outside IDLE are dropped. Optional FETCH_TIMEOUT_EN aborts a stalled REQ.
module pc_fetch_unit #(
    parameter logic [15:0] RESET_PC       = 16'h0000,
    parameter int          TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] next_pc,
    input  logic        pc_load,
    input  logic        fetch_start,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic [15:0] ir,
    output logic        ir_valid,
    output logic        busy,
    output logic [15:0] pc,
    output logic [15:0] pc_plus2,
    output logic [15:0] pc_branch,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Reject illegal configurations at elaboration rather than building a broken PC.
    if (RESET_PC[0] != 1'b0 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_cfg
        $error("pc_fetch_unit: RESET_PC must be even and TIMEOUT_CYCLES in 1..255");
    end

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic        imem_req_q, imem_req_d;
    logic        ir_valid_q, ir_valid_d;
    logic        busy_q, busy_d;
    logic        fetch_err_q, fetch_err_d;
    logic        timeout;

`ifdef FETCH_TIMEOUT_EN
    // Count of completed REQ cycles without ack; zero on REQ entry.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] cnt_q, cnt_d;

    // Counter advances only while requesting, so it is always zero when REQ is entered.
    always_comb begin
        cnt_d   = (state_q == S_REQ) ? cnt_q + 8'd1 : 8'd0;
        timeout = (state_q == S_REQ) && (cnt_q == TMO_LAST);
    end

    // Timeout counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    // Without the timeout option REQ waits for ack forever.
    assign timeout = 1'b0;
`endif

    // Next-state, PC and IR update; registered outputs are derived from the next state.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        fetch_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Load lands at this edge, so a same-cycle fetch uses the new PC.
                if (pc_load) begin
                    pc_d = {next_pc[15:1], 1'b0};
                end
                if (fetch_start) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                // An ack arriving on the timeout cycle still completes the fetch.
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    pc_d    = pc_q + 16'd2;
                    state_d = S_DONE;
                end else if (timeout) begin
                    state_d     = S_IDLE;
                    fetch_err_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        imem_req_d = (state_d == S_REQ);
        ir_valid_d = (state_d == S_DONE);
        busy_d     = (state_d != S_IDLE);
    end

    // State and output registers; reset drops imem_req immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            ir_q        <= 16'h0000;
            imem_req_q  <= 1'b0;
            ir_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            fetch_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            imem_req_q  <= imem_req_d;
            ir_valid_q  <= ir_valid_d;
            busy_q      <= busy_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    // Candidate next-PC values follow pc/ir directly so the mux sees them in the ir_valid cycle.
    always_comb begin
        pc_plus2  = pc_q + 16'd2;
        pc_branch = pc_plus2 + {{7{ir_q[7]}}, ir_q[7:0], 1'b0};
    end

    assign pc        = pc_q;
    assign ir        = ir_q;
    assign imem_addr = pc_q;
    assign imem_req  = imem_req_q;
    assign ir_valid  = ir_valid_q;
    assign busy      = busy_q;
    assign fetch_err = fetch_err_q;

endmodule
